// File: rtl/vrf_pkg.sv
// Shared types and widths for the VRF read path: request/response tag structs
// and the SRAM address helper.
package vrf_pkg;
    localparam int VS_W   = 5;
    localparam int RS_W   = 4;
    localparam int II_W   = 3;
    localparam int ADDR_W = 6;

    typedef struct packed {
        logic [VS_W-1:0] vs;
        logic            offset;
        logic [RS_W-1:0] readSource;
        logic [II_W-1:0] instructionIndex;
    } vrf_read_req_t;

    // Read data rides next to this struct; its width is a module parameter.
    typedef struct packed {
        logic [RS_W-1:0] readSource;
        logic [II_W-1:0] instructionIndex;
    } vrf_read_resp_t;

    function automatic logic [ADDR_W-1:0] vrf_addr(input vrf_read_req_t r);
        return {r.vs, r.offset};
    endfunction
endpackage

// File: rtl/vrf_resp_fifo.sv
// Response FIFO: registered occupancy count, pointers wrap modulo DEPTH so
// non-power-of-two depths work.
module vrf_resp_fifo #(
    parameter  int WIDTH = 39,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

    // Upstream credit accounting must make overflow and underflow unreachable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
        end
    end
endmodule

// File: rtl/vrf_read_pipe.sv
// VRF read pipe: credit-gated SRAM read issue, tag shift pipe matching the
// SRAM latency, and an in-order response FIFO.
module vrf_read_pipe
    import vrf_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [VS_W-1:0]       req_vs,
    input  logic                  req_offset,
    input  logic [RS_W-1:0]       req_readSource,
    input  logic [II_W-1:0]       req_instructionIndex,
    input  logic                  write_busy,
    output logic                  sram_re,
    output logic [ADDR_W-1:0]     sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [RS_W-1:0]       resp_readSource,
    output logic [II_W-1:0]       resp_instructionIndex
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(READ_LATENCY + 1);
    localparam int UW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
    localparam int FW = DATA_WIDTH + $bits(vrf_read_resp_t);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("vrf_read_pipe: READ_LATENCY must be 1..4");
    end
    if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
        $error("vrf_read_pipe: FIFO_DEPTH must be >= READ_LATENCY+2");
    end

    vrf_read_req_t           req;
    vrf_read_resp_t          resp_tag;
    vrf_read_resp_t          tag_pipe [1:READ_LATENCY];
    logic [READ_LATENCY:1]   vld_pipe;
    logic [IW-1:0]           inflight;
    logic [CW-1:0]           count;
    logic [FW-1:0]           fifo_rdata;
    logic                    fire;

    assign req = '{vs: req_vs, offset: req_offset,
                   readSource: req_readSource, instructionIndex: req_instructionIndex};

    always_comb begin
        inflight = '0;
        for (int i = 1; i <= READ_LATENCY; i++) inflight = inflight + IW'(vld_pipe[i]);
    end

    // Every read in flight reserves a FIFO slot; a pop frees its slot next cycle.
    assign req_ready = ~write_busy & ((UW'(inflight) + UW'(count)) < UW'(FIFO_DEPTH));
    assign fire      = req_valid & req_ready;
    assign sram_re   = fire;
    assign sram_addr = vrf_addr(req);

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= fire;
            for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clock) begin
        tag_pipe[1] <= '{readSource: req.readSource, instructionIndex: req.instructionIndex};
        for (int i = 2; i <= READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end

    assign resp_valid = (count != '0);

    vrf_resp_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (vld_pipe[READ_LATENCY]),
        .push_data ({sram_rdata, tag_pipe[READ_LATENCY]}),
        .pop       (resp_valid & resp_ready),
        .pop_data  (fifo_rdata),
        .count     (count)
    );

    assign {resp_data, resp_tag}  = fifo_rdata;
    assign resp_readSource        = resp_tag.readSource;
    assign resp_instructionIndex  = resp_tag.instructionIndex;
endmodule

// File: tb/tb_vrf_read_pipe.sv
// Bench for vrf_read_pipe: SRAM model, outstanding-count/queue reference
// model checked every cycle, table vectors and directed corner sequences.
module tb_vrf_read_pipe;
    localparam int DW = 32, RL = 2, DEPTH = 4;

    logic          clock, reset;
    logic          req_valid, req_ready, req_offset, write_busy;
    logic [4:0]    req_vs;
    logic [3:0]    req_readSource, resp_readSource;
    logic [2:0]    req_instructionIndex, resp_instructionIndex;
    logic          sram_re, resp_valid, resp_ready;
    logic [5:0]    sram_addr;
    logic [DW-1:0] sram_rdata, resp_data;

    vrf_read_pipe #(.DATA_WIDTH(DW), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_vs(req_vs), .req_offset(req_offset),
        .req_readSource(req_readSource), .req_instructionIndex(req_instructionIndex),
        .write_busy(write_busy),
        .sram_re(sram_re), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_readSource(resp_readSource), .resp_instructionIndex(resp_instructionIndex)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM: data valid exactly RL (=2) cycles after the read enable.
    logic [DW-1:0] mem [64];
    logic          re_d1, re_d2;
    logic [5:0]    a_d1, a_d2;
    always @(posedge clock) begin
        re_d1 <= sram_re;  a_d1 <= sram_addr;
        re_d2 <= re_d1;    a_d2 <= a_d1;
    end
    assign sram_rdata = re_d2 ? mem[a_d2] : 32'hBAD0BAD0;

    // Reference: reads owed to the requester in order, plus a slot count.
    typedef struct {
        logic [31:0] data;
        logic [3:0]  rs;
        logic [2:0]  ii;
        int          acc;
    } exp_t;
    exp_t q[$];
    int   cyc, outstanding, n_chk, n_fail;
    bit   model_en;
    logic exp_ready, exp_fire, exp_rv;

    typedef struct {
        logic       rv, wb;
        logic [4:0] vs;
        logic       off;
        logic       e_ready, e_re;
        logic [5:0] e_addr;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sample();
        @(negedge clock);
        exp_ready = !write_busy && (outstanding < DEPTH);
        exp_fire  = req_valid && exp_ready;
        exp_rv    = (q.size() > 0) && (cyc >= q[0].acc + RL + 1);
        if (model_en) begin
            check("m_req_ready", req_ready, exp_ready);
            check("m_sram_re", sram_re, exp_fire);
            if (exp_fire) check("m_sram_addr", sram_addr, {req_vs, req_offset});
            check("m_resp_valid", resp_valid, exp_rv);
            if (exp_rv) begin
                check("m_resp_data", resp_data, q[0].data);
                check("m_resp_rs", resp_readSource, q[0].rs);
                check("m_resp_ii", resp_instructionIndex, q[0].ii);
            end
        end
    endtask

    task automatic advance();
        exp_t e;
        if (reset) begin
            q.delete();
            outstanding = 0;
        end else begin
            if (exp_fire) begin
                e.data = mem[{req_vs, req_offset}];
                e.rs   = req_readSource;
                e.ii   = req_instructionIndex;
                e.acc  = cyc;
                q.push_back(e);
                outstanding++;
            end
            if (exp_rv && resp_ready) begin
                void'(q.pop_front());
                outstanding--;
            end
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic idle();
        req_valid = 0; write_busy = 0; resp_ready = 1;
    endtask

    task automatic rand_req();
        req_vs = 5'($urandom); req_offset = 1'($urandom);
        req_readSource = 4'($urandom); req_instructionIndex = 3'($urandom);
    endtask

    initial begin
        int acc, pops;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[7] = 32'hDEADBEEF;
        vecs[0] = '{1, 0, 5'd3,  1, 1, 1, 6'h07};
        vecs[1] = '{1, 1, 5'd5,  0, 0, 0, 6'h0A};
        vecs[2] = '{0, 0, 5'd31, 1, 1, 0, 6'h3F};
        vecs[3] = '{1, 0, 5'd31, 1, 1, 1, 6'h3F};
        vecs[4] = '{1, 0, 5'd0,  0, 1, 1, 6'h00};
        vecs[5] = '{0, 1, 5'd9,  1, 0, 0, 6'h13};
        vecs[6] = '{1, 0, 5'd16, 1, 1, 1, 6'h21};
        n_chk = 0; n_fail = 0; cyc = 0; outstanding = 0; model_en = 0;

        reset = 1; idle(); rand_req();
        tick(); tick();
        model_en = 1;
        reset = 0;

        // reset state
        sample();
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_sram_re", sram_re, 0);
        advance();

        // single read, fixed latency
        req_valid = 1; req_vs = 3; req_offset = 1; req_readSource = 4'h2; req_instructionIndex = 5;
        sample();
        check("single_re", sram_re, 1);
        check("single_addr", sram_addr, 6'h07);
        advance();
        req_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            sample();
            if (k < 3) check("single_early", resp_valid, 0);
            else begin
                check("single_valid", resp_valid, 1);
                check("single_data", resp_data, 32'hDEADBEEF);
                check("single_rs", resp_readSource, 4'h2);
                check("single_ii", resp_instructionIndex, 3'd5);
            end
            advance();
        end

        // table vectors from idle
        for (int i = 0; i < 7; i++) begin
            req_valid = vecs[i].rv; write_busy = vecs[i].wb;
            req_vs = vecs[i].vs; req_offset = vecs[i].off;
            req_readSource = 4'(i); req_instructionIndex = 3'(i);
            sample();
            check("vec_ready", req_ready, vecs[i].e_ready);
            check("vec_re", sram_re, vecs[i].e_re);
            if (vecs[i].e_re) check("vec_addr", sram_addr, vecs[i].e_addr);
            advance();
        end
        idle();
        repeat (6) tick();

        // back-to-back 8 with resp_ready high
        for (int i = 0; i < 12; i++) begin
            req_valid = (i < 8);
            rand_req();
            sample();
            if (i < 8) check("b2b_ready", req_ready, 1);
            check("b2b_resp_valid", resp_valid, (i >= 3 && i < 11));
            advance();
        end

        // backpressure fills the FIFO, then drains in order
        idle(); resp_ready = 0; acc = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1; rand_req();
            sample();
            if (req_valid && req_ready) acc++;
            if (i == 7) check("full_ready_low", req_ready, 0);
            advance();
        end
        check("full_accepts", acc, 4);
        req_valid = 0; resp_ready = 1; pops = 0;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (resp_valid) pops++;
            advance();
        end
        check("drain_pops", pops, 4);
        req_valid = 1; rand_req();
        sample();
        check("resume_ready", req_ready, 1);
        advance();
        idle();
        repeat (5) tick();

        // write_busy blocks issue only; pending read still returns on time
        req_valid = 1; rand_req();
        sample();
        check("wb_first_fire", sram_re, 1);
        advance();
        write_busy = 1;
        for (int k = 1; k <= 3; k++) begin
            rand_req();
            sample();
            check("wb_no_re", sram_re, 0);
            check("wb_not_ready", req_ready, 0);
            if (k == 3) check("wb_resp_slot", resp_valid, 1);
            advance();
        end
        idle();
        repeat (4) tick();

        // reset one cycle after a fire discards the read
        req_valid = 1; rand_req();
        tick();
        req_valid = 0; reset = 1;
        tick();
        reset = 0; write_busy = 1;
        sample();
        check("prst_ready_busy", req_ready, 0);
        check("prst_resp_valid", resp_valid, 0);
        advance();
        write_busy = 0;
        sample();
        check("prst_ready_free", req_ready, 1);
        check("prst_resp_valid2", resp_valid, 0);
        advance();
        for (int k = 0; k < 4; k++) begin
            sample();
            check("prst_no_resp", resp_valid, 0);
            advance();
        end

        // random traffic against the reference
        for (int i = 0; i < 10000; i++) begin
            req_valid  = ($urandom % 4) != 0;
            write_busy = ($urandom % 5) == 0;
            resp_ready = ($urandom % 3) != 0;
            rand_req();
            tick();
        end
        idle();
        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        check("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vrf_read_pipe.md
VRF_READ_PIPE -- requirements
Module: vrf_read_pipe

Parameters
REQ-001 SHALL have DATA_WIDTH, default 32, the VRF read data width.
REQ-002 SHALL have READ_LATENCY, default 2, the fixed SRAM cycles from sram_re to valid sram_rdata (legal 1..4).
REQ-003 SHALL have FIFO_DEPTH, default 4, the response FIFO entries; elaboration SHALL fail if FIFO_DEPTH < READ_LATENCY+2.

Interface
REQ-004 clock  in  1  clock; all state on posedge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  arbitrated read request present.
REQ-007 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-008 req_vs  in  5  vector register number.
REQ-009 req_offset  in  1  half-register offset.
REQ-010 req_readSource  in  4  requester tag, returned with data.
REQ-011 req_instructionIndex  in  3  instruction tag, returned with data.
REQ-012 write_busy  in  1  bank write port owns the SRAM this cycle.
REQ-013 sram_re  out  1  SRAM read enable.
REQ-014 sram_addr  out  6  SRAM address {req_vs, req_offset}.
REQ-015 sram_rdata  in  DATA_WIDTH  SRAM read data, READ_LATENCY cycles after sram_re.
REQ-016 resp_valid / resp_ready  out / in  1  response handshake.
REQ-017 resp_data  out  DATA_WIDTH  read data.
REQ-018 resp_readSource / resp_instructionIndex  out  4 / 3  returned tags.

Function
REQ-019 Accept (fire) SHALL be req_valid & req_ready; req_ready = ~write_busy & (inflight + count < FIFO_DEPTH), with inflight = valid stages in the tag pipe and count = FIFO occupancy; a same-cycle pop SHALL NOT add credit.
REQ-020 On fire in cycle T, sram_re SHALL be 1 and sram_addr = {req_vs, req_offset} in cycle T, combinationally; otherwise sram_re = 0.
REQ-021 Tags {readSource, instructionIndex} plus a valid bit SHALL travel a READ_LATENCY-stage shift pipe; in cycle T+READ_LATENCY the stage output SHALL push {sram_rdata, tags} into the FIFO.
REQ-022 resp_valid SHALL be count != 0 and first rises at T+READ_LATENCY+1; no bypass from sram_rdata to resp_data.
REQ-023 Responses SHALL leave in acceptance order; resp_* held stable while resp_valid & ~resp_ready.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged; push to a full FIFO SHALL be impossible by REQ-019 (assertion).
REQ-025 With resp_ready held high and write_busy low, throughput SHALL be one request per cycle.
REQ-026 write_busy high SHALL block acceptance that cycle only; in-flight reads SHALL complete unaffected.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH+1).

Reset
REQ-028 On reset: tag-pipe valids, FIFO pointers and count SHALL clear; sram_re = 0, resp_valid = 0; req_ready = ~write_busy in the first cycle after reset.
REQ-029 Reset mid-operation SHALL discard in-flight reads; sram_rdata returning afterwards SHALL be ignored.
REQ-030 Data/tag storage SHALL NOT require reset.

Structure
REQ-031 Package vrf_pkg SHALL hold the read-request struct (vs, offset, readSource, instructionIndex), the response struct, and constants VS_W=5, RS_W=4, II_W=3, ADDR_W=6.
REQ-032 FIFO SHALL be sub-module vrf_resp_fifo (synchronous, registered output-side occupancy); pipe and credit logic stay in vrf_read_pipe.

Verification
REQ-033 Single read: vs=3, offset=1, readSource=4'h2, ii=5 at T -> sram_addr=6'h07 at T; rdata=0xDEADBEEF at T+2 -> resp at T+3 with readSource=2, ii=5.
REQ-034 Back-to-back 8 requests, resp_ready=1 -> req_ready never drops, 8 in-order responses on consecutive cycles.
REQ-035 resp_ready=0, stream requests -> exactly 4 accepted then req_ready=0; resp_ready=1 -> 4 drained in order, acceptance resumes.
REQ-036 write_busy=1 for 3 cycles with req_valid=1 -> no sram_re those cycles; pending response still delivered at its slot.
REQ-037 Reset asserted one cycle after a fire -> resp_valid stays 0 afterwards, sram_rdata at T+2 dropped.
REQ-038 Random valid/ready/write_busy, 10k cycles -> scoreboard matches data and tags in order, no FIFO overflow assertion.
